// File: rtl/mcu0_intc.sv
// Vectored interrupt controller for the MCU0 core: 7 prioritised sources (1 highest),
// per-source enable/pending/in-service bits and a single, non-nesting service slot.
module mcu0_intc #(
  parameter bit TRIG_EDGE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] irq_in,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  output logic       interrupt,
  output logic [2:0] irq,
  input  logic       int_ack,
  input  logic       int_eoi
);

  // state   | meaning
  // S_IDLE  | no request outstanding, waiting for an enabled pending source
  // S_REQ   | vector latched in irq, interrupt asserted, waiting for int_ack
  // S_SERVICE | CPU running the handler, waiting for int_eoi
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t     state_q, state_d;
  logic [2:0] irq_q, irq_d;
  logic [7:0] enable_q, enable_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] inservice_q, inservice_d;
  logic [7:0] irq_prev_q;

  logic [7:0] hw_set, sw_set, sw_clr, pend_keep;
  logic [7:0] ack_clr, isr_set, isr_clr;
  logic       cand_valid;
  logic [2:0] cand_idx;

  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (pending_q[i] && enable_q[i]) begin
        cand_valid = 1'b1;
        cand_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    hw_set    = TRIG_EDGE ? (irq_in & ~irq_prev_q) : irq_in;
    sw_set    = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : 8'h00;
    sw_clr    = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 8'h00;
    // Sets are applied after the clear so a same-cycle set always survives.
    pend_keep = (pending_q & ~sw_clr) | hw_set | sw_set;
    enable_d  = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : enable_q;
    state_d   = state_q;
    irq_d     = irq_q;
    ack_clr   = 8'h00;
    isr_set   = 8'h00;
    isr_clr   = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (cand_valid) begin
          state_d = S_REQ;
          irq_d   = cand_idx;
        end
      end
      S_REQ: begin
        // The request is withdrawn on the same edge its pending or enable bit drops.
        if (!(pend_keep[irq_q] && enable_d[irq_q])) begin
          state_d = S_IDLE;
        end else if (int_ack) begin
          state_d        = S_SERVICE;
          ack_clr[irq_q] = 1'b1;
          isr_set[irq_q] = 1'b1;
        end
      end
      S_SERVICE: begin
        if (int_eoi) begin
          state_d        = S_IDLE;
          isr_clr[irq_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pending_d   = ((pending_q & ~(sw_clr | ack_clr)) | hw_set | sw_set) & 8'hFE;
    inservice_d = ((inservice_q & ~isr_clr) | isr_set) & 8'hFE;
    enable_d    = enable_d & 8'hFE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      irq_q       <= 3'd0;
      enable_q    <= 8'h00;
      pending_q   <= 8'h00;
      inservice_q <= 8'h00;
      irq_prev_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      irq_prev_q  <= irq_in;
    end
  end

  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = enable_q;
      2'd1:    cfg_rdata = pending_q;
      2'd3:    cfg_rdata = inservice_q;
      default: cfg_rdata = 8'h00;
    endcase
  end

  assign interrupt = (state_q == S_REQ);
  assign irq       = irq_q;

endmodule

// File: doc/mcu0_intc.md
MCU0_INTC -- requirements
Module: mcu0_intc

Interface
REQ-001 Parameter: TRIG_EDGE, default 1, 1 = rising-edge-triggered sources, 0 = level-triggered sources.
REQ-002 Port: clock  in  1  system clock; all state updates on posedge.
REQ-003 Port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: irq_in  in  8  raw interrupt request lines; bit 0 reserved (vector 0 = reset address), ignored.
REQ-005 Port: cfg_we  in  1  configuration write strobe, one cycle.
REQ-006 Port: cfg_addr  in  2  register select: 0 ENABLE, 1 PENDING (W1C), 2 SWSET (write-only), 3 INSERVICE (read-only).
REQ-007 Port: cfg_wdata  in  8  write data.
REQ-008 Port: cfg_rdata  out  8  combinational read of register at cfg_addr; SWSET reads 0.
REQ-009 Port: interrupt  out  1  registered interrupt request to CPU.
REQ-010 Port: irq  out  3  registered vector number; CPU jumps to irq<<1.
REQ-011 Port: int_ack  in  1  one-cycle pulse: CPU has taken the interrupt.
REQ-012 Port: int_eoi  in  1  one-cycle pulse: CPU executed IRET.

Function
REQ-013 Edge mode: pending[i] set on any posedge where irq_in[i]=1 and previous sample=0; level mode: pending[i] set on every posedge where irq_in[i]=1.
REQ-014 pending[0], enable[0] and inservice[0] shall be constant 0.
REQ-015 SWSET write sets pending bits where cfg_wdata=1; PENDING write clears bits where cfg_wdata=1; a hardware or SWSET set in the same cycle as a clear shall win.
REQ-016 ENABLE write replaces enable[7:1]; takes effect on the following cycle.
REQ-017 Candidate = lowest-numbered i in 1..7 with pending[i]&enable[i]; index 1 has highest priority.
REQ-018 FSM states: IDLE, REQ, SERVICE.
REQ-019 IDLE -> REQ when a candidate exists; candidate index latched into irq at the same edge; interrupt=1 exactly while in REQ.
REQ-020 In REQ, irq shall hold the latched vector even if a higher-priority source becomes pending.
REQ-021 In REQ, if the latched source's pending or enable bit becomes 0 before int_ack, return to IDLE; interrupt deasserts on that edge.
REQ-022 REQ -> SERVICE on int_ack: clear pending[irq], set inservice[irq], interrupt=0 at the same edge.
REQ-023 SERVICE -> IDLE on int_eoi: clear inservice[irq]; no nesting, at most one inservice bit set.
REQ-024 While in SERVICE, interrupt shall remain 0; new requests accumulate as pending.
REQ-025 int_ack outside REQ and int_eoi outside SERVICE shall be ignored; int_ack and int_eoi asserted together in REQ: ack processed, eoi ignored.
REQ-026 Latency: irq_in rising before edge k -> pending after edge k -> interrupt=1 after edge k+1.
REQ-027 After eoi with further enabled pending sources, interrupt reasserts after the next edge (one IDLE cycle minimum).
REQ-028 A source re-triggered while its own request is in SERVICE shall set pending again and be serviced after eoi.

Reset
REQ-029 On reset: state IDLE, interrupt=0, irq=0, enable=0, pending=0, inservice=0, edge-detect history=0.
REQ-030 Reset asserted mid-REQ or mid-SERVICE shall abort immediately with all of the above values; no pending state survives.
REQ-031 In edge mode, a line already high at reset release shall register as one edge on the first clock.

Verification
REQ-032 ENABLE=0x04, pulse irq_in[2] -> pending=0x04 after 1 edge, interrupt=1, irq=2 after 2nd edge; int_ack -> interrupt=0, INSERVICE=0x04; int_eoi -> INSERVICE=0.
REQ-033 ENABLE=0xFE, raise irq_in[5] and irq_in[3] same cycle -> irq=3 first; after ack+eoi, irq=5 one cycle later.
REQ-034 In REQ with irq=6, pulse irq_in[1] -> irq stays 6 until ack; after eoi, irq=1 served next.
REQ-035 In REQ with irq=4, write ENABLE=0x00 -> interrupt=0 next edge, state IDLE, pending[4] remains 1; rewrite ENABLE=0x10 -> interrupt reasserts with irq=4.
REQ-036 SWSET 0x80 and PENDING clear 0x80 written in consecutive cycles while irq_in[7] pulses with the clear -> pending[7]=1; irq_in[0] pulses -> no interrupt ever.
REQ-037 Assert reset in SERVICE -> interrupt=0, irq=0, all registers 0 asynchronously; post-reset int_eoi ignored.
